dcb: RTL and testbench

// - Down counter, BCD. The down-counting partner of the team's up counter (ucb), used as a countdown timer.
// - Loads a DIGITS-wide BCD value, then decrements it once every DIV enabled clocks until it reaches zero.
// - Flags completion with a one-cycle pulse. Optionally auto-reloads.
// - Drives the seven-segment display path and timeout logic in the lab top level.

---
 rtl/dcb.sv | 117 +++++++++++
 tb/tb_dcb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dcb.sv
`default_nettype none
// dcb: BCD countdown timer. Loads a clamped BCD value and counts it down once per DIV enabled clocks,
// with a one-cycle done pulse at zero and optional auto-reload.
module dcb #(
   parameter int DIGITS = 2,
   parameter int DIV    = 1,
   parameter int RELOAD = 0
) (
   input  logic                dcb_clk,
   input  logic                dcb_rst,
   input  logic                dcb_en,
   input  logic                dcb_load,
   input  logic [4*DIGITS-1:0] dcb_load_val,
   output logic [4*DIGITS-1:0] dcb_out,
   output logic                dcb_zero,
   output logic                dcb_busy,
   output logic                dcb_done
);

   localparam int            W    = 4 * DIGITS;
   localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  cnt, cnt_nxt;
   logic [W-1:0]  rel, rel_nxt;
   logic [W-1:0]  clamped;
   logic [W-1:0]  dec_val;
   logic [PW-1:0] presc, presc_nxt;
   logic          done, done_nxt;
   logic          counting;
   logic          step;
   logic          borrow;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_clamp
         assign clamped[4*gi +: 4] = (dcb_load_val[4*gi +: 4] > 4'd9) ? 4'd9 : dcb_load_val[4*gi +: 4];
      end
   endgenerate

   // Ripple-borrow BCD decrement: a zero digit becomes 9 and passes the borrow upward.
   always_comb begin
      dec_val = cnt;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (cnt[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   assign counting = (state == RUN) || ((state == DONE) && (RELOAD != 0));
   assign step     = counting && dcb_en && (presc == PMAX);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rel_nxt   = rel;
      presc_nxt = presc;
      done_nxt  = 1'b0;
      if (dcb_load) begin
         cnt_nxt   = clamped;
         rel_nxt   = clamped;
         presc_nxt = '0;
         state_nxt = (clamped != '0) ? RUN : DONE;
      end else if (step) begin
         presc_nxt = '0;
         if (state == RUN) begin
            cnt_nxt = dec_val;
            if (dec_val == '0) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end
         end else if (rel != '0) begin
            cnt_nxt   = rel;
            state_nxt = RUN;
         end
      end else if (counting && dcb_en) begin
         presc_nxt = presc + 1'b1;
      end
   end

   always_ff @(posedge dcb_clk or posedge dcb_rst) begin
      if (dcb_rst) begin
         state <= IDLE;
         cnt   <= '0;
         rel   <= '0;
         presc <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rel   <= rel_nxt;
         presc <= presc_nxt;
         done  <= done_nxt;
      end
   end

   assign dcb_out  = cnt;
   assign dcb_zero = (cnt == '0);
   assign dcb_busy = (state == RUN);
   assign dcb_done = done;

endmodule
`default_nettype wire

// File: tb/tb_dcb.sv
`default_nettype none
// tb_dcb: four dcb configurations driven with shared directed and random stimulus,
// each checked every cycle against a decimal-arithmetic reference model.
module tb_dcb;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        load;
   logic [11:0] lv;
   logic [7:0]  o0, o1, o2;
   logic [11:0] o3;
   logic [3:0]  z, b, d;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dcb #(.DIGITS(2), .DIV(1), .RELOAD(0)) u0 (
      .dcb_clk(clk), .dcb_rst(rst), .dcb_en(en), .dcb_load(load), .dcb_load_val(lv[7:0]),
      .dcb_out(o0), .dcb_zero(z[0]), .dcb_busy(b[0]), .dcb_done(d[0]));
   dcb #(.DIGITS(2), .DIV(4), .RELOAD(0)) u1 (
      .dcb_clk(clk), .dcb_rst(rst), .dcb_en(en), .dcb_load(load), .dcb_load_val(lv[7:0]),
      .dcb_out(o1), .dcb_zero(z[1]), .dcb_busy(b[1]), .dcb_done(d[1]));
   dcb #(.DIGITS(2), .DIV(1), .RELOAD(1)) u2 (
      .dcb_clk(clk), .dcb_rst(rst), .dcb_en(en), .dcb_load(load), .dcb_load_val(lv[7:0]),
      .dcb_out(o2), .dcb_zero(z[2]), .dcb_busy(b[2]), .dcb_done(d[2]));
   dcb #(.DIGITS(3), .DIV(3), .RELOAD(1)) u3 (
      .dcb_clk(clk), .dcb_rst(rst), .dcb_en(en), .dcb_load(load), .dcb_load_val(lv),
      .dcb_out(o3), .dcb_zero(z[3]), .dcb_busy(b[3]), .dcb_done(d[3]));

   // Reference model: count held as a plain integer; phase 0=idle, 1=running, 2=finished.
   int c_div [4] = '{1, 4, 1, 3};
   int c_rel [4] = '{0, 0, 1, 1};
   int c_dig [4] = '{2, 2, 2, 3};
   int m_val [4];
   int m_rl  [4];
   int m_pc  [4];
   int m_ph  [4];
   bit m_done[4];

   function automatic int clamp_dec(input logic [11:0] v, input int nd);
      int r = 0;
      int p = 1;
      int dg;
      for (int i = 0; i < nd; i++) begin
         dg = int'(v[4*i +: 4]);
         if (dg > 9) dg = 9;
         r += dg * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [11:0] to_bcd(input int x);
      logic [11:0] r;
      int t = x;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [11:0] get_out(input int k);
      case (k)
         0:       return {4'h0, o0};
         1:       return {4'h0, o1};
         2:       return {4'h0, o2};
         default: return o3;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_val[k] = 0; m_rl[k] = 0; m_pc[k] = 0; m_ph[k] = 0; m_done[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int v;
      for (int k = 0; k < 4; k++) begin
         m_done[k] = 1'b0;
         if (load) begin
            v        = clamp_dec(lv, c_dig[k]);
            m_val[k] = v;
            m_rl[k]  = v;
            m_pc[k]  = 0;
            m_ph[k]  = (v != 0) ? 1 : 2;
         end else if (en && (m_ph[k] == 1 || (m_ph[k] == 2 && c_rel[k] == 1))) begin
            m_pc[k]++;
            if (m_pc[k] == c_div[k]) begin
               m_pc[k] = 0;
               if (m_ph[k] == 1) begin
                  m_val[k] = m_val[k] - 1;
                  if (m_val[k] == 0) begin
                     m_ph[k]   = 2;
                     m_done[k] = 1'b1;
                  end
               end else if (m_rl[k] != 0) begin
                  m_val[k] = m_rl[k];
                  m_ph[k]  = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         chk("out",  k, 32'(get_out(k)), 32'(to_bcd(m_val[k])));
         chk("zero", k, 32'(z[k]), 32'(m_val[k] == 0));
         chk("busy", k, 32'(b[k]), 32'(m_ph[k] == 1));
         chk("done", k, 32'(d[k]), 32'(m_done[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1 check_all();
   endtask

   task automatic drive(input bit e, input bit l, input logic [11:0] v);
      en   = e;
      load = l;
      lv   = v;
   endtask

   task automatic async_reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      #1 model_reset();
      check_all();
      chk("rst_out_now", 0, 32'(o0), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 12'h000);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;

      // Plain countdown from 12 with DIV=1, then hold at zero.
      drive(1'b1, 1'b1, 12'h012);
      tick();
      drive(1'b1, 1'b0, 12'h000);
      repeat (14) tick();

      // Prescaled count paused for three cycles after two enabled clocks.
      drive(1'b1, 1'b1, 12'h010);
      tick();
      drive(1'b1, 1'b0, 12'h000);
      repeat (2) tick();
      drive(1'b0, 1'b0, 12'h000);
      repeat (3) tick();
      drive(1'b1, 1'b0, 12'h000);
      repeat (6) tick();

      // Load of zero, clamped load, and load colliding with the zero crossing.
      drive(1'b1, 1'b1, 12'h000);
      tick();
      chk("load0_zero", 0, 32'(z[0]), 32'h1);
      chk("load0_done", 0, 32'(d[0]), 32'h0);
      drive(1'b1, 1'b1, 12'h0A5);
      tick();
      chk("clampA5", 0, 32'(o0), 32'h95);
      drive(1'b1, 1'b1, 12'h002);
      tick();
      drive(1'b1, 1'b0, 12'h000);
      tick();
      drive(1'b1, 1'b1, 12'h007);
      tick();
      chk("xload_done", 0, 32'(d[0]), 32'h0);
      chk("xload_out", 0, 32'(o0), 32'h07);

      // Asynchronous reset in the middle of a count.
      drive(1'b1, 1'b1, 12'h045);
      tick();
      drive(1'b1, 1'b0, 12'h000);
      repeat (3) tick();
      async_reset_pulse();

      // Auto-reload wraps.
      drive(1'b1, 1'b1, 12'h003);
      tick();
      drive(1'b1, 1'b0, 12'h000);
      repeat (12) tick();

      // Random traffic, including out-of-range digits and occasional resets.
      repeat (600) begin
         drive(($urandom % 4) != 0, ($urandom % 12) == 0, 12'($urandom));
         if (($urandom % 150) == 0) async_reset_pulse();
         else                       tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
